// File: rtl/avg_pkg.sv
// avg_pkg: shared definitions for the avg_mov_n averager.
//   state_t      - controller states (IDLE / FILL / RUN)
//   MODE_MOVING  - sliding-window average, one output per accepted sample
//   MODE_BLOCK   - decimating average, one output per N accepted samples
//   acc_width()  - accumulator width that holds the sum of N full-scale samples
package avg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam logic MODE_MOVING = 1'b0;
  localparam logic MODE_BLOCK  = 1'b1;

  // Sum of 2^log2_n samples of width bits needs log2_n extra bits.
  function automatic int acc_width(input int width, input int log2_n);
    return width + log2_n;
  endfunction

endpackage

// File: rtl/avg_ring_buf.sv
// avg_ring_buf: N x WIDTH sample store for the sliding window.
// Ports:
//   clk    - system clock, rising edge
//   we     - write enable for wdata at addr
//   addr   - ring position (write pointer)
//   wdata  - sample to store
//   rdata  - combinational read of the entry at addr (value before this
//            cycle's write, so the oldest sample is seen as it is replaced)
// Contents are deliberately not reset so the array maps onto distributed RAM.
module avg_ring_buf #(
  parameter int WIDTH  = 16,
  parameter int LOG2_N = 7
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [LOG2_N-1:0]        addr,
  input  logic signed [WIDTH-1:0]  wdata,
  output logic signed [WIDTH-1:0]  rdata
);

  logic signed [WIDTH-1:0] mem_r [0:(1<<LOG2_N)-1];

  // Sample storage write port; no reset on the array.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end
  end

  assign rdata = mem_r[addr];

endmodule

// File: rtl/avg_mov_n.sv
// avg_mov_n: signed moving / block averager over N = 2^LOG2_N samples.
// Ports:
//   clk      - system clock, rising edge
//   rst      - asynchronous active-low reset
//   start_i  - enable; low forces IDLE, high leaves IDLE into FILL
//   mode_i   - 0 moving, 1 block; captured only when leaving IDLE
//   clear_i  - synchronous restart of the window (back to FILL)
//   valid_i  - qualifier for data_i
//   data_i   - signed input sample
//   valid_o  - one-cycle strobe, data_o carries a new average
//   data_o   - signed average (holds between strobes)
//   filled_o - high while the sliding window is full (RUN)
// Build option: define AVG_ROUND_EN to round half toward +inf instead of
// truncating toward -inf.
module avg_mov_n
  import avg_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int LOG2_N = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic                     mode_i,
  input  logic                     clear_i,
  input  logic                     valid_i,
  input  logic signed [WIDTH-1:0]  data_i,
  output logic                     valid_o,
  output logic signed [WIDTH-1:0]  data_o,
  output logic                     filled_o
);

  localparam int ACC_W = acc_width(WIDTH, LOG2_N);
  localparam int CNT_W = LOG2_N + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << LOG2_N) - 1);
`ifdef AVG_ROUND_EN
  localparam logic signed [ACC_W-1:0] RND_C = ACC_W'(1) << (LOG2_N - 1);
`endif

  state_t                    state_r, state_nxt_s;
  logic                      mode_r, mode_nxt_s;
  logic signed [ACC_W-1:0]   acc_r, acc_nxt_s;
  logic [CNT_W-1:0]          cnt_r, cnt_nxt_s;
  logic [LOG2_N-1:0]         wr_ptr_r, ptr_nxt_s;
  logic                      valid_r, valid_nxt_s;
  logic signed [WIDTH-1:0]   data_r, data_nxt_s;
  logic                      filled_r;
  logic                      we_s;
  logic signed [WIDTH-1:0]   ring_rd_s;
  logic signed [ACC_W-1:0]   x_ext_s, old_ext_s, sum_s, rnd_s;
  logic signed [WIDTH-1:0]   avg_s;
  logic                      last_s;

  avg_ring_buf #(.WIDTH(WIDTH), .LOG2_N(LOG2_N)) u_ring (
    .clk   (clk),
    .we    (we_s),
    .addr  (wr_ptr_r),
    .wdata (data_i),
    .rdata (ring_rd_s)
  );

  // Candidate next accumulator value: the outgoing sample only counts once
  // the window is full, so stale RAM contents never leak in during FILL.
  assign x_ext_s   = {{LOG2_N{data_i[WIDTH-1]}}, data_i};
  assign old_ext_s = (state_r == ST_RUN) ? {{LOG2_N{ring_rd_s[WIDTH-1]}}, ring_rd_s}
                                         : {ACC_W{1'b0}};
  assign sum_s     = acc_r + x_ext_s - old_ext_s;
`ifdef AVG_ROUND_EN
  assign rnd_s     = sum_s + RND_C;
`else
  assign rnd_s     = sum_s;
`endif
  assign avg_s     = WIDTH'(rnd_s >>> LOG2_N);
  assign last_s    = (state_r == ST_FILL) && (cnt_r == CNT_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; start_i low overrides everything, then clear_i.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_i) state_nxt_s = ST_FILL;
        else         state_nxt_s = ST_IDLE;
      end
      ST_FILL: begin
        if (!start_i)                                      state_nxt_s = ST_IDLE;
        else if (clear_i)                                  state_nxt_s = ST_FILL;
        else if (valid_i && last_s && mode_r == MODE_MOVING) state_nxt_s = ST_RUN;
        else                                               state_nxt_s = ST_FILL;
      end
      ST_RUN: begin
        if (!start_i)     state_nxt_s = ST_IDLE;
        else if (clear_i) state_nxt_s = ST_FILL;
        else              state_nxt_s = ST_RUN;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Datapath and output next values per state.
  always_comb begin
    acc_nxt_s   = acc_r;
    cnt_nxt_s   = cnt_r;
    ptr_nxt_s   = wr_ptr_r;
    mode_nxt_s  = mode_r;
    we_s        = 1'b0;
    valid_nxt_s = 1'b0;
    data_nxt_s  = data_r;
    case (state_r)
      ST_IDLE: begin
        if (start_i) begin
          acc_nxt_s  = {ACC_W{1'b0}};
          cnt_nxt_s  = {CNT_W{1'b0}};
          ptr_nxt_s  = {LOG2_N{1'b0}};
          mode_nxt_s = mode_i;
        end else begin
          mode_nxt_s = mode_r;
        end
      end
      ST_FILL, ST_RUN: begin
        if (!start_i) begin
          valid_nxt_s = 1'b0;
        end else if (clear_i) begin
          acc_nxt_s = {ACC_W{1'b0}};
          cnt_nxt_s = {CNT_W{1'b0}};
          ptr_nxt_s = {LOG2_N{1'b0}};
        end else if (valid_i) begin
          if (mode_r == MODE_BLOCK) begin
            if (last_s) begin
              acc_nxt_s   = {ACC_W{1'b0}};
              cnt_nxt_s   = {CNT_W{1'b0}};
              valid_nxt_s = 1'b1;
              data_nxt_s  = avg_s;
            end else begin
              acc_nxt_s = sum_s;
              cnt_nxt_s = cnt_r + CNT_W'(1);
            end
          end else begin
            acc_nxt_s = sum_s;
            we_s      = 1'b1;
            ptr_nxt_s = wr_ptr_r + LOG2_N'(1);
            if (state_r == ST_FILL) cnt_nxt_s = cnt_r + CNT_W'(1);
            else                    cnt_nxt_s = cnt_r;
            if (state_r == ST_RUN || last_s) begin
              valid_nxt_s = 1'b1;
              data_nxt_s  = avg_s;
            end else begin
              valid_nxt_s = 1'b0;
            end
          end
        end else begin
          valid_nxt_s = 1'b0;
        end
      end
      default: begin
        valid_nxt_s = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_r    <= {ACC_W{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      wr_ptr_r <= {LOG2_N{1'b0}};
      mode_r   <= MODE_MOVING;
      valid_r  <= 1'b0;
      data_r   <= {WIDTH{1'b0}};
      filled_r <= 1'b0;
    end else begin
      acc_r    <= acc_nxt_s;
      cnt_r    <= cnt_nxt_s;
      wr_ptr_r <= ptr_nxt_s;
      mode_r   <= mode_nxt_s;
      valid_r  <= valid_nxt_s;
      data_r   <= data_nxt_s;
      filled_r <= (state_nxt_s == ST_RUN);
    end
  end

  assign valid_o  = valid_r;
  assign data_o   = data_r;
  assign filled_o = filled_r;

endmodule
